// File: rtl/ser_link_pkg.sv
// Definitions shared by both ends of the 8-bit serial link (transmitter and comma-hunting receiver).
package ser_link_pkg;

  localparam int FRAME_BITS = 8;
  localparam logic [FRAME_BITS-1:0] COMMA = 8'hBC;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } link_state_e;

endpackage

// File: rtl/partoserial_tx_if.sv
// Byte source <-> serial transmitter signal bundle.
interface partoserial_tx_if;
  import ser_link_pkg::*;

  logic [FRAME_BITS-1:0] data_in;
  logic                  valid_in;
  logic                  ready_out;
  logic                  resync;
  logic                  data_out;
  logic                  frame_start;
  logic                  sending_data;
  logic                  sync_done;
  logic                  comma_err;

  modport master (
    output data_in, valid_in, resync,
    input  ready_out, data_out, frame_start, sending_data, sync_done, comma_err
  );

  modport slave (
    input  data_in, valid_in, resync,
    output ready_out, data_out, frame_start, sending_data, sync_done, comma_err
  );

endinterface

// File: rtl/partoserial_tx.sv
// Byte-to-serial transmitter, MSB first, with comma frames for receiver lock.
//   state | meaning
//   SYNC  | sending MIN_SYNC_COMMAS commas back to back, no data accepted
//   RUN   | data bytes sent when offered, commas otherwise
module partoserial_tx
  import ser_link_pkg::*;
#(
  parameter int unsigned           MIN_SYNC_COMMAS = 8,
  parameter logic [FRAME_BITS-1:0] COMMA           = ser_link_pkg::COMMA
) (
  input logic             clk,
  input logic             reset,
  partoserial_tx_if.slave bus
);

  localparam int               CNT_W    = $clog2(MIN_SYNC_COMMAS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_SYNC_COMMAS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       BIT_LAST = 3'(FRAME_BITS - 1);

  link_state_e           r_state;
  link_state_e           w_state_nxt;
  logic [CNT_W-1:0]      r_comma_cnt;
  logic [CNT_W-1:0]      w_comma_cnt_nxt;
  logic                  r_resync_pend;
  logic                  w_resync_pend_nxt;
  logic [FRAME_BITS-1:0] r_shift_reg;
  logic [2:0]            r_bit_cnt;
  logic                  r_sending_data;
  logic                  r_comma_err;

  logic w_load;
  logic w_resync_req;
  logic w_ready;
  logic w_accept;

  assign w_load       = (r_bit_cnt == BIT_LAST);
  // A resync arriving on the load edge itself must already block acceptance there.
  assign w_resync_req = r_resync_pend | bus.resync;
  assign w_ready      = (r_state == RUN) && w_load && !w_resync_req;
  assign w_accept     = w_ready && bus.valid_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= SYNC;
      r_comma_cnt   <= '0;
      r_resync_pend <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_comma_cnt   <= w_comma_cnt_nxt;
      r_resync_pend <= w_resync_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_comma_cnt_nxt   = r_comma_cnt;
    w_resync_pend_nxt = r_resync_pend | bus.resync;
    if (w_load) begin
      w_resync_pend_nxt = 1'b0;
      case (r_state)
        SYNC: begin
          if (w_resync_req) begin
            w_comma_cnt_nxt = CNT_ONE;
          end else if (r_comma_cnt == CNT_LAST) begin
            w_state_nxt     = RUN;
            w_comma_cnt_nxt = '0;
          end else begin
            w_comma_cnt_nxt = r_comma_cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (w_resync_req) begin
            w_state_nxt     = SYNC;
            w_comma_cnt_nxt = CNT_ONE;
          end
        end
        default: w_state_nxt = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift_reg    <= '0;
      r_bit_cnt      <= BIT_LAST;
      r_sending_data <= 1'b0;
      r_comma_err    <= 1'b0;
    end else if (w_load) begin
      r_shift_reg    <= w_accept ? bus.data_in : COMMA;
      r_bit_cnt      <= '0;
      r_sending_data <= w_accept;
      // A data byte equal to the comma is still sent; the far end may mis-align on it.
      if (w_accept && (bus.data_in == COMMA)) r_comma_err <= 1'b1;
    end else begin
      r_shift_reg <= {r_shift_reg[FRAME_BITS-2:0], 1'b0};
      r_bit_cnt   <= r_bit_cnt + 3'd1;
    end
  end

  assign bus.data_out     = r_shift_reg[FRAME_BITS-1];
  assign bus.frame_start  = (r_bit_cnt == 3'd0);
  assign bus.ready_out    = w_ready;
  assign bus.sending_data = r_sending_data;
  assign bus.sync_done    = (r_state == RUN);
  assign bus.comma_err    = r_comma_err;

endmodule

// File: tb/tb_partoserial_tx.sv
// Directed bench for partoserial_tx: sync sequence, data frames, comma error, resync and mid-frame reset.
module tb_partoserial_tx;
  import ser_link_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  partoserial_tx_if u_if ();

  partoserial_tx #(
    .MIN_SYNC_COMMAS (8),
    .COMMA           (8'hBC)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge where bit_cnt==7; returns at the next such negedge.
  task automatic collect(input int pulse_at, output logic [7:0] byte_o, output logic sd_o);
    logic [7:0] acc;
    acc  = 8'h00;
    sd_o = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      u_if.resync = (i == pulse_at);
      acc = {acc[6:0], u_if.data_out};
      if (i == 0) sd_o = u_if.sending_data;
      chk("frame_start", 32'(u_if.frame_start), 32'(i == 0));
      if (i < 7) chk("ready_mid", 32'(u_if.ready_out), 32'd0);
    end
    byte_o = acc;
  endtask

  task automatic sync_sequence();
    logic [7:0] b;
    logic       sd;
    for (int j = 0; j < 8; j++) begin
      chk("sync_ready", 32'(u_if.ready_out), 32'd0);
      collect(-1, b, sd);
      chk("sync_byte", 32'(b), 32'h0000_00BC);
      chk("sync_sending", 32'(sd), 32'd0);
      chk("sync_done", 32'(u_if.sync_done), 32'(j == 7));
    end
    chk("first_ready", 32'(u_if.ready_out), 32'd1);
  endtask

  logic [7:0] r_byte;
  logic       r_sd;
  logic [7:0] b2b [3] = '{8'h01, 8'hFF, 8'h3C};

  initial begin
    u_if.data_in  = 8'h00;
    u_if.valid_in = 1'b0;
    u_if.resync   = 1'b0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_data_out", 32'(u_if.data_out), 32'd0);
    chk("rst_frame_start", 32'(u_if.frame_start), 32'd0);
    chk("rst_sending", 32'(u_if.sending_data), 32'd0);
    chk("rst_sync_done", 32'(u_if.sync_done), 32'd0);
    chk("rst_comma_err", 32'(u_if.comma_err), 32'd0);
    chk("rst_ready", 32'(u_if.ready_out), 32'd0);

    reset = 1'b0;
    sync_sequence();

    u_if.data_in  = 8'hA5;
    u_if.valid_in = 1'b1;
    collect(-1, r_byte, r_sd);
    chk("a5_byte", 32'(r_byte), 32'h0000_00A5);
    chk("a5_sending", 32'(r_sd), 32'd1);
    chk("a5_ready_again", 32'(u_if.ready_out), 32'd1);
    collect(-1, r_byte, r_sd);
    chk("a5_repeat", 32'(r_byte), 32'h0000_00A5);

    for (int k = 0; k < 3; k++) begin
      u_if.data_in = b2b[k];
      chk("b2b_ready", 32'(u_if.ready_out), 32'd1);
      collect(-1, r_byte, r_sd);
      chk("b2b_byte", 32'(r_byte), 32'(b2b[k]));
      chk("b2b_sending", 32'(r_sd), 32'd1);
    end

    u_if.valid_in = 1'b0;
    chk("idle_ready", 32'(u_if.ready_out), 32'd1);
    collect(-1, r_byte, r_sd);
    chk("idle_byte", 32'(r_byte), 32'h0000_00BC);
    chk("idle_sending", 32'(r_sd), 32'd0);

    chk("cerr_before", 32'(u_if.comma_err), 32'd0);
    u_if.data_in  = 8'hBC;
    u_if.valid_in = 1'b1;
    collect(-1, r_byte, r_sd);
    chk("cerr_byte", 32'(r_byte), 32'h0000_00BC);
    chk("cerr_sending", 32'(r_sd), 32'd1);
    chk("cerr_set", 32'(u_if.comma_err), 32'd1);
    u_if.data_in = 8'h5A;
    collect(-1, r_byte, r_sd);
    chk("cerr_next_byte", 32'(r_byte), 32'h0000_005A);
    chk("cerr_sticky", 32'(u_if.comma_err), 32'd1);

    u_if.data_in = 8'h96;
    collect(3, r_byte, r_sd);
    chk("resync_frame_byte", 32'(r_byte), 32'h0000_0096);
    chk("resync_frame_sending", 32'(r_sd), 32'd1);
    u_if.data_in = 8'h77;
    sync_sequence();
    collect(-1, r_byte, r_sd);
    chk("post_resync_byte", 32'(r_byte), 32'h0000_0077);
    chk("post_resync_sending", 32'(r_sd), 32'd1);

    u_if.data_in = 8'h81;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_data_out", 32'(u_if.data_out), 32'd0);
    chk("mid_rst_frame_start", 32'(u_if.frame_start), 32'd0);
    chk("mid_rst_comma_err", 32'(u_if.comma_err), 32'd0);
    chk("mid_rst_sync_done", 32'(u_if.sync_done), 32'd0);
    chk("mid_rst_ready", 32'(u_if.ready_out), 32'd0);
    chk("mid_rst_sending", 32'(u_if.sending_data), 32'd0);
    u_if.valid_in = 1'b0;
    reset = 1'b0;
    sync_sequence();
    chk("mid_rst_cerr_after", 32'(u_if.comma_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
